// File: rtl/tdm_mux_8x1_if.sv
// Handshake and serial-slot bundle for the 8:1 TDM multiplexer.
// The slave side is the multiplexer; the master side feeds words and watches slots.
interface tdm_mux_8x1_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_mask;
  logic       in_ready;
  logic       out_bit;
  logic [2:0] out_sel;
  logic       out_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_mask,
    output in_ready, out_bit, out_sel, out_valid, frame_start, frame_end, busy
  );

  modport master (
    output in_valid, in_data, in_mask,
    input  in_ready, out_bit, out_sel, out_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/tdm_mux_8x1.sv
// Sequential 8:1 TDM multiplexer: serialises the enabled bits of a captured word,
// one channel per clock, in ascending or descending channel order.
module tdm_mux_8x1 #(
  parameter bit ASCEND = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_mux_8x1_if.slave   bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state, state_nxt;
  logic [7:0] data_r, data_nxt;
  logic [7:0] mask_r, mask_nxt;
  logic [2:0] sel_r, sel_nxt;
  logic       bit_r, bit_nxt;
  logic       valid_r, valid_nxt;
  logic       fs_r, fs_nxt;
  logic       fe_r, fe_nxt;

  logic [3:0] cur_next;   // {found, channel} of the enabled channel after sel_r
  logic [3:0] cur_after;  // {found, channel} of the one after that
  logic [3:0] new_first;
  logic [3:0] new_after;
  logic       last;
  logic       ready;
  logic       accept;

  // Scan position of a channel: position 0 is scanned first.
  function automatic logic [3:0] pos_of(input logic [2:0] ch);
    return {1'b0, (ASCEND ? ch : 3'd7 - ch)};
  endfunction

  // First enabled channel at scan position >= start; MSB flags a hit.
  function automatic logic [3:0] find_from(input logic [7:0] mask, input logic [3:0] start);
    logic [3:0] res;
    logic [2:0] ch;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      ch = ASCEND ? 3'(i) : 3'(7 - i);
      if (4'(i) >= start && mask[ch]) res = {1'b1, ch};
    end
    return res;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cur_next  = find_from(mask_r, pos_of(sel_r) + 4'd1);
    cur_after = find_from(mask_r, pos_of(cur_next[2:0]) + 4'd1);
    new_first = find_from(bus.in_mask, 4'd0);
    new_after = find_from(bus.in_mask, pos_of(new_first[2:0]) + 4'd1);
    last      = ~cur_next[3];
    ready     = (state == IDLE) || last;
    accept    = bus.in_valid && ready;

    state_nxt = state;
    data_nxt  = data_r;
    mask_nxt  = mask_r;
    sel_nxt   = sel_r;
    bit_nxt   = 1'b0;
    valid_nxt = 1'b0;
    fs_nxt    = 1'b0;
    fe_nxt    = 1'b0;

    if (accept) begin
      data_nxt = bus.in_data;
      mask_nxt = bus.in_mask;
    end

    if (state == SCAN && !last) begin
      state_nxt = SCAN;
      sel_nxt   = cur_next[2:0];
      bit_nxt   = data_r[cur_next[2:0]];
      valid_nxt = 1'b1;
      fe_nxt    = ~cur_after[3];
    end else if (accept && new_first[3]) begin
      // New frame, either from IDLE or back-to-back off the last slot.
      state_nxt = SCAN;
      sel_nxt   = new_first[2:0];
      bit_nxt   = bus.in_data[new_first[2:0]];
      valid_nxt = 1'b1;
      fs_nxt    = 1'b1;
      fe_nxt    = ~new_after[3];
    end else begin
      state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_r  <= '0;
      mask_r  <= '0;
      sel_r   <= '0;
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
      fs_r    <= 1'b0;
      fe_r    <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_r  <= data_nxt;
      mask_r  <= mask_nxt;
      sel_r   <= sel_nxt;
      bit_r   <= bit_nxt;
      valid_r <= valid_nxt;
      fs_r    <= fs_nxt;
      fe_r    <= fe_nxt;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_bit     = bit_r;
  assign bus.out_sel     = sel_r;
  assign bus.out_valid   = valid_r;
  assign bus.frame_start = fs_r;
  assign bus.frame_end   = fe_r;
  assign bus.busy        = valid_r;

endmodule
